// File: rtl/udp_pkg.sv
// Shared types and protocol constants for the UDP receive parser.
// Also used by the preamble/SFD detector.
package udp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ETH_HDR,
    IP_HDR,
    UDP_HDR,
    PAYLOAD,
    SKIP
  } state_t;

  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
  localparam int unsigned ETH_HDR_LEN    = 14;
  localparam int unsigned UDP_HDR_LEN    = 8;
  localparam logic [7:0]  PREAMBLE_BYTE  = 8'h55;
  localparam logic [7:0]  SFD_BYTE       = 8'hD5;

  // Index of the final IPv4 header byte for a given IHL (header is IHL 32-bit words).
  function automatic logic [15:0] ip_hdr_last(input logic [3:0] ihl);
    return {10'd0, ihl, 2'b00} - 16'd1;
  endfunction

endpackage

// File: rtl/udp_sfd_detect.sv
// Preamble/SFD detector: counts consecutive 0x55 bytes while enabled and
// flags an accepted 0xD5 that follows at least PREAMBLE_MIN of them.
module udp_sfd_detect
  import udp_pkg::*;
#(
  parameter int unsigned PREAMBLE_MIN = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  input  logic       enable,
  output logic       sfd
);

  localparam int unsigned   CW  = $clog2(PREAMBLE_MIN + 1) + 1;
  localparam logic [CW-1:0] SAT = CW'(PREAMBLE_MIN);

  logic [CW-1:0] cnt_q;

  assign sfd = rx_valid && enable && (rx_byte == SFD_BYTE) && (cnt_q >= SAT);

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (rx_valid) begin
      if (enable && rx_byte == PREAMBLE_BYTE) begin
        if (cnt_q != SAT) cnt_q <= cnt_q + CW'(1);
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/udp_rx_parser.sv
// Byte-stream Ethernet/IPv4/UDP receive parser: strips headers, streams the
// UDP payload one cycle after acceptance and counts rejected frames.
module udp_rx_parser
  import udp_pkg::*;
#(
  parameter int unsigned PREAMBLE_MIN   = 7,
  parameter bit          PORT_FILTER_EN = 1'b0,
  parameter logic [15:0] DEST_PORT      = 16'd5000,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             main_clk,
  input  logic             main_rst_n,
  input  logic [7:0]       eth_byte,
  input  logic             input_ready,
  output logic             valid_ip,
  output logic             valid_udp,
  output logic [7:0]       udp_byte,
  output logic             udp_valid,
  output logic             udp_last,
  output logic [15:0]      udp_dst_port,
  output logic [15:0]      udp_len,
  output logic [CNT_W-1:0] drop_cnt
);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  ihl_q;
  logic        proto_ok_q;
  logic [7:0]  type_hi_q;
  logic [15:0] port_q, len_q;
  logic        sfd, sfd_en;
  logic        reject, ip_ok, udp_ok, pay_last;

  logic             valid_ip_d, valid_udp_d, udp_valid_d, udp_last_d;
  logic [7:0]       udp_byte_d;
  logic [15:0]      udp_dst_port_d, udp_len_d;
  logic [CNT_W-1:0] drop_cnt_d;

  // Preamble hunting only happens between frames; header and payload parsing is length-driven.
  assign sfd_en = (state_q == IDLE) || (state_q == SKIP);

  udp_sfd_detect #(
    .PREAMBLE_MIN(PREAMBLE_MIN)
  ) u_sfd (
    .clk     (main_clk),
    .rst_n   (main_rst_n),
    .rx_byte (eth_byte),
    .rx_valid(input_ready),
    .enable  (sfd_en),
    .sfd     (sfd)
  );

  // State register plus header field capture.
  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ihl_q      <= '0;
      proto_ok_q <= 1'b0;
      type_hi_q  <= '0;
      port_q     <= '0;
      len_q      <= '0;
    end else if (input_ready) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      case (state_q)
        ETH_HDR: if (cnt_q == 16'd12) type_hi_q <= eth_byte;
        IP_HDR: begin
          if (cnt_q == 16'd0) ihl_q <= eth_byte[3:0];
          if (cnt_q == 16'd9) proto_ok_q <= (eth_byte == IP_PROTO_UDP);
        end
        UDP_HDR: begin
          case (cnt_q)
            16'd2:   port_q[15:8] <= eth_byte;
            16'd3:   port_q[7:0]  <= eth_byte;
            16'd4:   len_q[15:8]  <= eth_byte;
            16'd5:   len_q[7:0]   <= eth_byte;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    reject   = 1'b0;
    ip_ok    = 1'b0;
    udp_ok   = 1'b0;
    pay_last = 1'b0;
    if (input_ready) begin
      cnt_d = cnt_q + 16'd1;
      case (state_q)
        IDLE, SKIP: begin
          cnt_d = '0;
          if (sfd) state_d = ETH_HDR;
        end
        ETH_HDR: if (cnt_q == 16'(ETH_HDR_LEN - 1)) begin
          cnt_d = '0;
          if ({type_hi_q, eth_byte} == ETHERTYPE_IPV4) begin
            state_d = IP_HDR;
          end else begin
            state_d = SKIP;
            reject  = 1'b1;
          end
        end
        IP_HDR: begin
          if (cnt_q == 16'd0) begin
            if (eth_byte[7:4] != 4'd4 || eth_byte[3:0] < 4'd5) begin
              state_d = SKIP;
              reject  = 1'b1;
            end
          end else if (cnt_q == ip_hdr_last(ihl_q)) begin
            cnt_d = '0;
            if (proto_ok_q) begin
              state_d = UDP_HDR;
              ip_ok   = 1'b1;
            end else begin
              state_d = SKIP;
              reject  = 1'b1;
            end
          end
        end
        UDP_HDR: if (cnt_q == 16'(UDP_HDR_LEN - 1)) begin
          cnt_d = '0;
          if (len_q < 16'(UDP_HDR_LEN) || (PORT_FILTER_EN && port_q != DEST_PORT)) begin
            state_d = SKIP;
            reject  = 1'b1;
          end else begin
            udp_ok  = 1'b1;
            state_d = (len_q == 16'(UDP_HDR_LEN)) ? SKIP : PAYLOAD;
          end
        end
        PAYLOAD: if (cnt_q == len_q - 16'd9) begin
          cnt_d    = '0;
          pay_last = 1'b1;
          state_d  = SKIP;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output logic; everything is registered so pulses land one cycle after the byte.
  always_comb begin
    valid_ip_d     = ip_ok;
    valid_udp_d    = udp_ok;
    udp_valid_d    = input_ready && (state_q == PAYLOAD);
    udp_byte_d     = udp_valid_d ? eth_byte : 8'h00;
    udp_last_d     = pay_last;
    udp_dst_port_d = udp_ok ? port_q : udp_dst_port;
    udp_len_d      = udp_ok ? (len_q - 16'd8) : udp_len;
    drop_cnt_d     = (reject && drop_cnt != '1) ? drop_cnt + CNT_W'(1) : drop_cnt;
  end

  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      valid_ip     <= 1'b0;
      valid_udp    <= 1'b0;
      udp_byte     <= 8'h00;
      udp_valid    <= 1'b0;
      udp_last     <= 1'b0;
      udp_dst_port <= '0;
      udp_len      <= '0;
      drop_cnt     <= '0;
    end else begin
      valid_ip     <= valid_ip_d;
      valid_udp    <= valid_udp_d;
      udp_byte     <= udp_byte_d;
      udp_valid    <= udp_valid_d;
      udp_last     <= udp_last_d;
      udp_dst_port <= udp_dst_port_d;
      udp_len      <= udp_len_d;
      drop_cnt     <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_udp_rx_parser.sv
// Directed bench for udp_rx_parser: a default instance and a port-filtering
// instance with a 2-bit drop counter share one byte stream.
`timescale 1ns/1ps
module tb_udp_rx_parser;

  logic       main_clk    = 1'b0;
  logic       main_rst_n  = 1'b0;
  logic [7:0] eth_byte    = 8'h00;
  logic       input_ready = 1'b0;

  logic        valid_ip [2];
  logic        valid_udp [2];
  logic [7:0]  udp_byte [2];
  logic        udp_valid [2];
  logic        udp_last [2];
  logic [15:0] udp_dst_port [2];
  logic [15:0] udp_len [2];
  logic [15:0] drop0;
  logic [1:0]  drop1;

  always #5 main_clk = ~main_clk;

  udp_rx_parser dut (
    .main_clk(main_clk), .main_rst_n(main_rst_n), .eth_byte(eth_byte), .input_ready(input_ready),
    .valid_ip(valid_ip[0]), .valid_udp(valid_udp[0]), .udp_byte(udp_byte[0]), .udp_valid(udp_valid[0]),
    .udp_last(udp_last[0]), .udp_dst_port(udp_dst_port[0]), .udp_len(udp_len[0]), .drop_cnt(drop0)
  );

  udp_rx_parser #(.PORT_FILTER_EN(1'b1), .DEST_PORT(16'd5000), .CNT_W(2)) dut_f (
    .main_clk(main_clk), .main_rst_n(main_rst_n), .eth_byte(eth_byte), .input_ready(input_ready),
    .valid_ip(valid_ip[1]), .valid_udp(valid_udp[1]), .udp_byte(udp_byte[1]), .udp_valid(udp_valid[1]),
    .udp_last(udp_last[1]), .udp_dst_port(udp_dst_port[1]), .udp_len(udp_len[1]), .drop_cnt(drop1)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  int         ip_n [2];
  int         udp_n [2];
  int         last_n [2];
  int         last_idx [2];
  logic [7:0] got0 [$];
  logic [7:0] got1 [$];

  always @(negedge main_clk) begin
    for (int i = 0; i < 2; i++) begin
      if (valid_ip[i])  ip_n[i]++;
      if (valid_udp[i]) udp_n[i]++;
    end
    if (udp_valid[0]) got0.push_back(udp_byte[0]);
    if (udp_valid[1]) got1.push_back(udp_byte[1]);
    if (udp_last[0]) begin last_n[0]++; last_idx[0] = got0.size() - 1; end
    if (udp_last[1]) begin last_n[1]++; last_idx[1] = got1.size() - 1; end
  end

  task automatic clear_mon();
    for (int i = 0; i < 2; i++) begin
      ip_n[i] = 0; udp_n[i] = 0; last_n[i] = 0; last_idx[i] = -1;
    end
    got0.delete();
    got1.delete();
  endtask

  typedef struct {
    string       name;
    int          pre_n;
    logic [3:0]  ver;
    logic [3:0]  ihl;
    logic [15:0] etype;
    logic [7:0]  proto;
    logic [15:0] dport;
    logic [15:0] ulen;
    int          pay_n;
    logic [63:0] pay;
    bit          gaps;
    int          sel;
    int          e_ip;
    int          e_udp;
    int          e_beats;
    logic [15:0] e_len;
    logic [15:0] e_port;
    int          e_drop0;
    int          e_drop1;
  } vec_t;

  function automatic vec_t mk(string name, int pre_n, int ver, int ihl, int etype, int proto,
                              int dport, int ulen, int pay_n, logic [63:0] pay, bit gaps, int sel,
                              int e_ip, int e_udp, int e_beats, int e_len, int e_port,
                              int e_drop0, int e_drop1);
    vec_t v;
    v.name = name; v.pre_n = pre_n; v.ver = 4'(ver); v.ihl = 4'(ihl);
    v.etype = 16'(etype); v.proto = 8'(proto); v.dport = 16'(dport); v.ulen = 16'(ulen);
    v.pay_n = pay_n; v.pay = pay; v.gaps = gaps; v.sel = sel;
    v.e_ip = e_ip; v.e_udp = e_udp; v.e_beats = e_beats;
    v.e_len = 16'(e_len); v.e_port = 16'(e_port); v.e_drop0 = e_drop0; v.e_drop1 = e_drop1;
    return v;
  endfunction

  function automatic logic [7:0] pay_byte(input logic [63:0] pay, input int i);
    return pay[63 - 8*i -: 8];
  endfunction

  logic [7:0] frm [$];

  task automatic build(input vec_t v);
    frm.delete();
    repeat (v.pre_n) frm.push_back(8'h55);
    frm.push_back(8'hD5);
    repeat (6) frm.push_back(8'hFF);
    frm.push_back(8'h02); frm.push_back(8'h11); frm.push_back(8'h22);
    frm.push_back(8'h33); frm.push_back(8'h44); frm.push_back(8'h66);
    frm.push_back(v.etype[15:8]); frm.push_back(v.etype[7:0]);
    for (int i = 0; i < 4 * int'(v.ihl); i++) begin
      if (i == 0)      frm.push_back({v.ver, v.ihl});
      else if (i == 8) frm.push_back(8'h40);
      else if (i == 9) frm.push_back(v.proto);
      else             frm.push_back(i >= 20 ? 8'h01 : 8'h00);
    end
    frm.push_back(8'h12); frm.push_back(8'h34);
    frm.push_back(v.dport[15:8]); frm.push_back(v.dport[7:0]);
    frm.push_back(v.ulen[15:8]); frm.push_back(v.ulen[7:0]);
    frm.push_back(8'h00); frm.push_back(8'h00);
    for (int i = 0; i < v.pay_n; i++) frm.push_back(pay_byte(v.pay, i));
    frm.push_back(8'hA5); frm.push_back(8'h5A); frm.push_back(8'hC3); frm.push_back(8'h3C);
    frm.push_back(8'h00); frm.push_back(8'h00);
  endtask

  // Drives from posedge+1; stall cycles present 0xD5 to prove it is ignored.
  task automatic send(input bit gaps, input int nmax);
    for (int i = 0; i < frm.size() && i < nmax; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          eth_byte = 8'hD5; input_ready = 1'b0;
          @(posedge main_clk); #1;
        end
      end
      eth_byte = frm[i]; input_ready = 1'b1;
      @(posedge main_clk); #1;
    end
    input_ready = 1'b0;
    eth_byte    = 8'h00;
  endtask

  localparam int NV = 13;
  vec_t vec [NV];
  int   ed0 = 0;
  int   ed1 = 0;

  task automatic check_outputs_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      check({tag, " valid_ip"}, valid_ip[i], 0);
      check({tag, " valid_udp"}, valid_udp[i], 0);
      check({tag, " udp_valid"}, udp_valid[i], 0);
      check({tag, " udp_last"}, udp_last[i], 0);
      check({tag, " udp_byte"}, udp_byte[i], 0);
      check({tag, " udp_dst_port"}, udp_dst_port[i], 0);
      check({tag, " udp_len"}, udp_len[i], 0);
    end
    check({tag, " drop_cnt"}, drop0, 0);
    check({tag, " drop_cnt_f"}, drop1, 0);
  endtask

  task automatic check_vec(input vec_t v);
    int         s;
    int         nb;
    logic [7:0] b;
    s  = v.sel;
    nb = (s == 0) ? got0.size() : got1.size();
    check({v.name, " valid_ip pulses"}, ip_n[s], v.e_ip);
    check({v.name, " valid_udp pulses"}, udp_n[s], v.e_udp);
    check({v.name, " payload beats"}, nb, v.e_beats);
    for (int i = 0; i < v.e_beats && i < nb; i++) begin
      b = (s == 0) ? got0[i] : got1[i];
      check($sformatf("%s byte%0d", v.name, i), b, pay_byte(v.pay, i));
    end
    check({v.name, " udp_last count"}, last_n[s], (v.e_beats > 0) ? 1 : 0);
    if (v.e_beats > 0) check({v.name, " udp_last position"}, last_idx[s], v.e_beats - 1);
    check({v.name, " udp_len"}, udp_len[s], v.e_len);
    check({v.name, " udp_dst_port"}, udp_dst_port[s], v.e_port);
    check({v.name, " drop_cnt"}, drop0, ed0);
    check({v.name, " drop_cnt_f"}, drop1, ed1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t r;
    //          name          pre ver ihl etype    proto dport ulen pn payload                gap sel ip udp bt len port  d0 d1
    vec[0]  = mk("basic",      7, 4, 5,  'h0800, 'h11, 5000, 12, 4, 64'hDEADBEEF_00000000, 0, 0, 1, 1, 4, 4, 5000, 0, 0);
    vec[1]  = mk("ihl7",       7, 4, 7,  'h0800, 'h11, 5000, 12, 4, 64'hDEADBEEF_00000000, 0, 0, 1, 1, 4, 4, 5000, 0, 0);
    vec[2]  = mk("ipv6",       7, 4, 5,  'h86DD, 'h11, 5000, 12, 4, 64'hDEADBEEF_00000000, 0, 0, 0, 0, 0, 4, 5000, 1, 1);
    vec[3]  = mk("after_drop", 7, 4, 5,  'h0800, 'h11, 5000, 12, 4, 64'hDEADBEEF_00000000, 1, 0, 1, 1, 4, 4, 5000, 0, 0);
    vec[4]  = mk("port5001",   7, 4, 5,  'h0800, 'h11, 5001, 12, 4, 64'hDEADBEEF_00000000, 0, 1, 1, 0, 0, 4, 5000, 0, 1);
    vec[5]  = mk("ulen8",      7, 4, 5,  'h0800, 'h11, 5000, 8,  0, 64'h0,                 0, 1, 1, 1, 0, 0, 5000, 0, 0);
    vec[6]  = mk("sfd_in_pay", 7, 4, 5,  'h0800, 'h11, 5000, 16, 8, 64'h55555555_555555D5, 0, 0, 1, 1, 8, 8, 5000, 0, 0);
    vec[7]  = mk("bad_ver",    7, 6, 5,  'h0800, 'h11, 5000, 12, 4, 64'hDEADBEEF_00000000, 0, 0, 0, 0, 0, 8, 5000, 1, 1);
    vec[8]  = mk("bad_proto",  7, 4, 5,  'h0800, 'h06, 5000, 12, 4, 64'hDEADBEEF_00000000, 0, 0, 0, 0, 0, 8, 5000, 1, 1);
    vec[9]  = mk("ulen7",      7, 4, 5,  'h0800, 'h11, 5000, 7,  0, 64'h0,                 0, 0, 1, 0, 0, 8, 5000, 1, 1);
    vec[10] = mk("short_pre",  6, 4, 5,  'h0800, 'h11, 5000, 12, 4, 64'hDEADBEEF_00000000, 0, 0, 0, 0, 0, 8, 5000, 0, 0);
    vec[11] = mk("ihl4",       7, 4, 4,  'h0800, 'h11, 5000, 12, 4, 64'hDEADBEEF_00000000, 0, 0, 0, 0, 0, 8, 5000, 1, 1);
    vec[12] = mk("ihl15",      7, 4, 15, 'h0800, 'h11, 5000, 12, 4, 64'hCAFEF00D_00000000, 1, 0, 1, 1, 4, 4, 5000, 0, 0);

    clear_mon();
    repeat (3) @(posedge main_clk);
    #1;
    check_outputs_zero("reset");
    main_rst_n = 1'b1;
    repeat (2) @(posedge main_clk);
    #1;

    for (int k = 0; k < NV; k++) begin
      clear_mon();
      build(vec[k]);
      send(vec[k].gaps, 100000);
      repeat (4) @(posedge main_clk);
      #1;
      ed0 = ed0 + vec[k].e_drop0;
      ed1 = (ed1 + vec[k].e_drop1 > 3) ? 3 : ed1 + vec[k].e_drop1;
      check_vec(vec[k]);
    end

    // Reset asserted after the third payload byte of a 16-byte-length frame.
    clear_mon();
    r = mk("rst_mid", 7, 4, 5, 'h0800, 'h11, 5000, 16, 8, 64'h11223344_55667788, 0, 0,
           1, 1, 3, 0, 0, 0, 0);
    build(r);
    send(1'b0, 7 + 1 + 14 + 20 + 8 + 3);
    #6 main_rst_n = 1'b0;
    #1;
    check_outputs_zero("rst_mid");
    repeat (2) @(posedge main_clk);
    #1;
    check("rst_mid held udp_valid", udp_valid[0], 0);
    check("rst_mid held drop_cnt", drop0, 0);
    main_rst_n = 1'b1;
    ed0 = 0;
    ed1 = 0;
    check("rst_mid beats before reset", got0.size(), 3);
    for (int i = 0; i < 3 && i < got0.size(); i++)
      check($sformatf("rst_mid byte%0d", i), got0[i], pay_byte(r.pay, i));
    check("rst_mid no udp_last", last_n[0], 0);

    repeat (2) @(posedge main_clk);
    #1;
    clear_mon();
    r = vec[0];
    r.name = "post_reset";
    r.gaps = 1'b1;
    build(r);
    send(1'b1, 100000);
    repeat (4) @(posedge main_clk);
    #1;
    check_vec(r);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/udp_rx_parser.md
UDP_RX_PARSER -- requirements
Module: udp_rx_parser

Interface
REQ-001 SHALL have parameter PREAMBLE_MIN, default 7: minimum consecutive 0x55 bytes required before 0xD5 SFD.
REQ-002 SHALL have parameter PORT_FILTER_EN, default 0: 1 enables UDP destination-port filtering.
REQ-003 SHALL have parameter DEST_PORT, default 16'd5000: accepted UDP destination port when filtering is enabled.
REQ-004 SHALL have parameter CNT_W, default 16: width of the drop counter.
REQ-005 SHALL have port main_clk, input, 1: sole clock; all logic on rising edge.
REQ-006 SHALL have port main_rst_n, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port eth_byte, input, 8: received byte stream.
REQ-008 SHALL have port input_ready, input, 1: eth_byte is valid this cycle; no byte is consumed when low.
REQ-009 SHALL have port valid_ip, output, 1: one-cycle pulse on an accepted IPv4 header.
REQ-010 SHALL have port valid_udp, output, 1: one-cycle pulse on an accepted UDP header.
REQ-011 SHALL have port udp_byte, output, 8: payload byte.
REQ-012 SHALL have port udp_valid, output, 1: udp_byte is valid.
REQ-013 SHALL have port udp_last, output, 1: marks the final payload byte.
REQ-014 SHALL have port udp_dst_port, output, 16: destination port, held from UDP header completion until the next frame.
REQ-015 SHALL have port udp_len, output, 16: payload length (UDP length - 8), held with udp_dst_port.
REQ-016 SHALL have port drop_cnt, output, CNT_W: count of rejected frames, saturating.

Function
REQ-017 SHALL use states IDLE, ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, SKIP; the state advances only on cycles with input_ready=1.
REQ-018 SHALL track in IDLE and SKIP a saturating count of consecutive 0x55 bytes; 0xD5 with count >= PREAMBLE_MIN -> ETH_HDR with byte counter 0; any other byte clears the count.
REQ-019 SHALL ignore SFD patterns in ETH_HDR, IP_HDR, UDP_HDR and PAYLOAD (length-driven parsing).
REQ-020 SHALL in ETH_HDR take 14 bytes; bytes 12-13 = 0x0800 -> IP_HDR, else SKIP.
REQ-021 SHALL in IP_HDR check byte 0: upper nibble must be 4 and IHL >= 5, else SKIP on that byte; header length = IHL*4 bytes (20-60); options are consumed and discarded.
REQ-022 SHALL check protocol byte 9 = 0x11 at the end of the IP header; on pass, pulse valid_ip the cycle after the last IP header byte and go to UDP_HDR, else SKIP.
REQ-023 SHALL in UDP_HDR take 8 bytes: dst port = bytes 2-3, length = bytes 4-5 (big-endian).
REQ-024 SHALL reject to SKIP if UDP length < 8, or if PORT_FILTER_EN=1 and dst port != DEST_PORT.
REQ-025 SHALL otherwise pulse valid_udp, load udp_dst_port/udp_len, and enter PAYLOAD; if UDP length = 8, go to SKIP with no payload beats.
REQ-026 SHALL emit each payload byte on udp_byte with udp_valid=1 exactly one cycle after it is accepted; udp_valid=0 otherwise.
REQ-027 SHALL assert udp_last with the udp_len-th byte, then go to SKIP; trailing bytes (FCS, padding) are discarded.
REQ-028 SHALL increment drop_cnt once per frame rejected in REQ-020/021/022/024, saturating at all-ones with no wrap.
REQ-029 SHALL keep a stall (input_ready=0) from changing state or counters, and from asserting valid outputs the following cycle.

Reset
REQ-030 SHALL on main_rst_n=0 immediately force state to IDLE, preamble count 0, all outputs 0 (udp_byte 8'h00, drop_cnt 0); assertion mid-payload terminates the frame with no udp_last.
REQ-031 SHALL resume operation on the first rising edge after deassertion.

Structure
REQ-032 SHALL place the state enum, ETHERTYPE_IPV4 (16'h0800), IP_PROTO_UDP (8'h11), ETH_HDR_LEN (14) and UDP_HDR_LEN (8) in package udp_pkg.
REQ-033 SHALL implement the preamble/SFD detector as sub-module udp_sfd_detect (inputs byte/valid/enable, output sfd pulse).

Verification
REQ-034 SHALL cover: 7x55, D5, 14-byte Ethernet header with type 0800, IHL=5 proto 11, UDP dst 5000 len 12, payload DE AD BE EF -> valid_ip, valid_udp, 4 udp_valid beats with udp_last on EF, udp_len=4.
REQ-035 SHALL cover: the same frame with IHL=7 (8 option bytes) -> identical payload output.
REQ-036 SHALL cover: ethertype 0x86DD -> no valid_ip, drop_cnt +1; the next valid frame parses normally.
REQ-037 SHALL cover: PORT_FILTER_EN=1, dst port 5001 -> valid_ip only, drop_cnt +1; UDP length 8 -> valid_udp with no payload beats.
REQ-038 SHALL cover: payload containing 55 55 55 55 55 55 55 D5 -> bytes passed through, no restart.
REQ-039 SHALL cover: random input_ready=0 gaps and main_rst_n low mid-payload -> byte order preserved, outputs zero during reset.
